tzn32: RTL and testbench
========================

TZN32 -- requirements
Module: tzn32

Interface
REQ-001 Parameter WIDTH, default 32: data width; SHALL be a power of two, 2..64, with elaboration error otherwise.
REQ-002 Derived constant NUMZ_W = $clog2(WIDTH)+1: count width; a count of WIDTH fits.
REQ-003 Port clk_i, input, 1: single clock; all state rises on its positive edge.
REQ-004 Port rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port valid_i, input, 1: a_i carries a valid operand this cycle.
REQ-006 Port a_i, input, WIDTH: operand whose trailing zeros are counted.
REQ-007 Port valid_o, output, 1: numz_o and zero_o hold a valid result.
REQ-008 Port numz_o, output, NUMZ_W: number of consecutive zero bits from bit 0 upward.
REQ-009 Port zero_o, output, 1: operand was all zeros.

Function
REQ-010 numz_o SHALL equal the index of the least-significant set bit of a_i.
REQ-011 When a_i is all zeros, numz_o SHALL equal WIDTH (32 at default) and zero_o SHALL be 1; otherwise zero_o SHALL be 0.
REQ-012 Latency SHALL be exactly one clock: a_i sampled with valid_i=1 at edge N appears on numz_o/zero_o after edge N, with valid_o=1.
REQ-013 valid_o SHALL be valid_i delayed by one clock; the block accepts one operand every cycle, with no backpressure and no stall.
REQ-014 When valid_i=0 at an edge, numz_o and zero_o SHALL hold their previous values and valid_o SHALL go 0.
REQ-015 Counting SHALL use a log2(WIDTH)-level binary tree: each node merges the (all-zero flag, count) pairs of its low and high halves. Count = low count when the low half is nonzero; otherwise half-width plus high count.
REQ-016 No X propagation: any fully defined a_i SHALL yield a fully defined result.
REQ-017 Boundary cases: a_i=1 -> 0; a_i=MSB only (0x8000_0000) -> WIDTH-1 = 31; a_i all ones -> 0.

Reset
REQ-018 While rst_ni=0, valid_o SHALL be 0, numz_o SHALL be 0 and zero_o SHALL be 0, asynchronously and independent of clk_i.
REQ-019 After rst_ni deasserts, the first result SHALL appear one edge after the first valid_i=1 edge.
REQ-020 Asserting reset mid-stream SHALL discard the in-flight result; valid_o SHALL not pulse for it.

Structure
REQ-021 A shared package tzn_pkg SHALL hold the default WIDTH and a function computing NUMZ_W from a width.
REQ-022 The combinational tree SHALL be one sub-module, tzn_node, recursively or generate-instantiated per level.
REQ-023 tzn32 SHALL add only the input-qualified output register stage and the reset logic around the tree.

Verification
REQ-024 Sweep a_i = 0..99 with valid_i=1: numz_o equals the trailing-zero count one cycle later. Examples: 0 -> 32 with zero_o=1, 8 -> 3, 96 -> 5.
REQ-025 Walking one, a_i = 1<<k for k = 0..31 -> numz_o = k, zero_o = 0.
REQ-026 a_i = 0xFFFF_FFFF -> 0; a_i = 0x8000_0000 -> 31; a_i = 0 -> 32 with zero_o = 1.
REQ-027 valid_i=1 with 0x10, then valid_i=0 with 0x1 -> numz_o stays 4 and valid_o drops to 0.
REQ-028 Assert rst_ni low between clock edges during a stream -> outputs go to 0 immediately and no stale valid_o follows.
REQ-029 Random 10k operands at WIDTH=32 and WIDTH=8, checked against a reference model -> zero mismatches.

Source files
------------

// File: rtl/tzn_pkg.sv
// Shared constants and helpers for the trailing-zero counter.
package tzn_pkg;

    localparam int TZN_WIDTH = 32;

    function automatic int numz_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/tzn_node.sv
// Recursive trailing-zero tree node: merges (all-zero, count) of two halves.
module tzn_node
    import tzn_pkg::*;
#(
    parameter int W  = 32,
    parameter int NW = numz_w(W)
) (
    input  logic [W-1:0]  a,
    output logic          zero,
    output logic [NW-1:0] cnt
);

    if (W == 1) begin : g_leaf
        // A zero leaf counts as its full width of one.
        assign zero = ~a[0];
        assign cnt  = ~a[0];
    end else begin : g_node
        localparam int H  = W / 2;
        localparam int HW = numz_w(H);

        logic          lo_z;
        logic          hi_z;
        logic [HW-1:0] lo_c;
        logic [HW-1:0] hi_c;

        tzn_node #(.W(H)) u_lo (
            .a    (a[H-1:0]),
            .zero (lo_z),
            .cnt  (lo_c)
        );

        tzn_node #(.W(H)) u_hi (
            .a    (a[W-1:H]),
            .zero (hi_z),
            .cnt  (hi_c)
        );

        assign zero = lo_z & hi_z;
        assign cnt  = lo_z ? NW'(H) + NW'(hi_c) : NW'(lo_c);
    end

endmodule

// File: rtl/tzn32.sv
// Trailing-zero counter with a single input-qualified output register.
module tzn32
    import tzn_pkg::*;
#(
    parameter int WIDTH  = TZN_WIDTH,
    localparam int NUMZ_W = numz_w(WIDTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [WIDTH-1:0]  a_i,
    output logic              valid_o,
    output logic [NUMZ_W-1:0] numz_o,
    output logic              zero_o
);

    if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("tzn32: WIDTH must be a power of two in 2..64");
    end

    logic              tree_zero;
    logic [NUMZ_W-1:0] tree_cnt;

    tzn_node #(.W(WIDTH)) u_tree (
        .a    (a_i),
        .zero (tree_zero),
        .cnt  (tree_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            numz_o  <= '0;
            zero_o  <= 1'b0;
        end else begin
            valid_o <= valid_i;
            // Result holds while no operand is presented.
            if (valid_i) begin
                numz_o <= tree_cnt;
                zero_o <= tree_zero;
            end
        end
    end

endmodule

// File: tb/tb_tzn32.sv
// Scoreboard bench for tzn32 at WIDTH=32 and WIDTH=8.
module tb_tzn32;

    typedef struct packed {
        logic [6:0] n;
        logic       z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [31:0] a_i;
    logic [7:0]  b_i;
    logic        valid_o, bvalid_o;
    logic [5:0]  numz_o;
    logic [3:0]  bnumz_o;
    logic        zero_o, bzero_o;

    int checks   = 0;
    int failures = 0;

    exp_t q32[$];
    exp_t q8[$];
    exp_t last32, last8;

    always #5 clk = ~clk;

    tzn32 u_dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .a_i     (a_i),
        .valid_o (valid_o),
        .numz_o  (numz_o),
        .zero_o  (zero_o)
    );

    tzn32 #(.WIDTH(8)) u_dut8 (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .a_i     (b_i),
        .valid_o (bvalid_o),
        .numz_o  (bnumz_o),
        .zero_o  (bzero_o)
    );

    function automatic exp_t mk(input logic [31:0] a, input int w);
        exp_t e;
        e.n = 7'(w);
        e.z = 1'b1;
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i]) begin
                e.n = 7'(i);
                e.z = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic apply(input logic v, input logic [31:0] a, input logic [7:0] b);
        valid_i = v;
        a_i     = a;
        b_i     = b;
        if (v) begin
            q32.push_back(mk(a, 32));
            q8.push_back(mk({24'h0, b}, 8));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_ni  = 1'b0;
        valid_i = 1'b1;
        a_i     = 32'h10;
        b_i     = 8'h10;
        #3;
        checks++;
        if (valid_o !== 1'b0 || numz_o !== 6'd0 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got v=%b n=%0d z=%b want 0 0 0",
                     valid_o, numz_o, zero_o);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b0 || numz_o !== 6'd0 || zero_o !== 1'b0 ||
            bvalid_o !== 1'b0 || bnumz_o !== 4'd0 || bzero_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_clocked got v=%b n=%0d z=%b v8=%b n8=%0d z8=%b want 0",
                     valid_o, numz_o, zero_o, bvalid_o, bnumz_o, bzero_o);
        end
        valid_i = 1'b0;
        #2;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got v=%b want 0", valid_o);
        end
    endtask

    task automatic test_sweep;
        exp_t e, f;
        for (int i = 0; i < 100; i++) begin
            apply(1'b1, 32'(i), 8'(i));
            checks++;
            if (q32.size() == 0 || q8.size() == 0) begin
                failures++;
                $display("FAIL sweep_queue a=%0d empty", i);
                continue;
            end
            e = q32.pop_front();
            f = q8.pop_front();
            if (valid_o !== 1'b1 || numz_o !== e.n[5:0] || zero_o !== e.z ||
                bvalid_o !== 1'b1 || bnumz_o !== f.n[3:0] || bzero_o !== f.z) begin
                failures++;
                $display("FAIL sweep a=%0d got v=%b n=%0d z=%b n8=%0d z8=%b want n=%0d z=%b n8=%0d z8=%b",
                         i, valid_o, numz_o, zero_o, bnumz_o, bzero_o, e.n, e.z, f.n, f.z);
            end
        end
    endtask

    task automatic test_walk;
        exp_t e, f;
        for (int k = 0; k < 32; k++) begin
            apply(1'b1, 32'h1 << k, 8'h80 >> (k % 8));
            checks++;
            if (q32.size() == 0 || q8.size() == 0) begin
                failures++;
                $display("FAIL walk_queue k=%0d empty", k);
                continue;
            end
            e = q32.pop_front();
            f = q8.pop_front();
            if (valid_o !== 1'b1 || numz_o !== 6'(k) || zero_o !== 1'b0 ||
                bnumz_o !== f.n[3:0] || bzero_o !== 1'b0) begin
                failures++;
                $display("FAIL walk k=%0d got n=%0d z=%b n8=%0d want n=%0d z=0 n8=%0d",
                         k, numz_o, zero_o, bnumz_o, e.n, f.n);
            end
        end
    endtask

    task automatic test_boundary;
        logic [31:0] av [4];
        logic [5:0]  nv [4];
        logic        zv [4];
        logic [3:0]  n8 [4];
        exp_t e, f;
        av = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h1};
        nv = '{6'd0, 6'd31, 6'd32, 6'd0};
        zv = '{1'b0, 1'b0, 1'b1, 1'b0};
        n8 = '{4'd0, 4'd7, 4'd8, 4'd0};
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, av[i], (i == 1) ? 8'h80 : av[i][7:0]);
            e = q32.pop_front();
            f = q8.pop_front();
            checks++;
            if (valid_o !== 1'b1 || numz_o !== nv[i] || zero_o !== zv[i] ||
                bnumz_o !== n8[i] || bzero_o !== zv[i]) begin
                failures++;
                $display("FAIL boundary a=%h got n=%0d z=%b n8=%0d z8=%b want n=%0d z=%b n8=%0d",
                         av[i], numz_o, zero_o, bnumz_o, bzero_o, nv[i], zv[i], n8[i]);
            end
            if (e.n[5:0] !== nv[i] || f.n[3:0] !== n8[i]) begin
                $display("note: model disagrees with table at %0d", i);
            end
        end
    endtask

    task automatic test_hold;
        exp_t e, f;
        apply(1'b1, 32'h10, 8'h10);
        e = q32.pop_front();
        f = q8.pop_front();
        checks++;
        if (valid_o !== 1'b1 || numz_o !== 6'd4 || bnumz_o !== 4'd4) begin
            failures++;
            $display("FAIL hold_load got v=%b n=%0d n8=%0d want 1 4 4 (model %0d %0d)",
                     valid_o, numz_o, bnumz_o, e.n, f.n);
        end
        apply(1'b0, 32'h1, 8'h1);
        checks++;
        if (valid_o !== 1'b0 || numz_o !== 6'd4 || zero_o !== 1'b0 ||
            bvalid_o !== 1'b0 || bnumz_o !== 4'd4) begin
            failures++;
            $display("FAIL hold_idle got v=%b n=%0d z=%b v8=%b n8=%0d want 0 4 0 0 4",
                     valid_o, numz_o, zero_o, bvalid_o, bnumz_o);
        end
        last32 = '{n: 7'd4, z: 1'b0};
        last8  = '{n: 7'd4, z: 1'b0};
    endtask

    task automatic test_random;
        exp_t e, f;
        logic [31:0] a;
        logic        v;
        int          sent;
        sent = 0;
        while (sent < 10000) begin
            v = ($urandom_range(0, 7) != 0);
            a = $urandom << $urandom_range(0, 32);
            apply(v, a, 8'($urandom >> $urandom_range(0, 31)) << $urandom_range(0, 8));
            checks++;
            if (v) begin
                sent++;
                e = q32.pop_front();
                f = q8.pop_front();
                if (valid_o !== 1'b1 || numz_o !== e.n[5:0] || zero_o !== e.z ||
                    bvalid_o !== 1'b1 || bnumz_o !== f.n[3:0] || bzero_o !== f.z) begin
                    failures++;
                    $display("FAIL random a=%h b=%h got n=%0d z=%b n8=%0d z8=%b want n=%0d z=%b n8=%0d z8=%b",
                             a, b_i, numz_o, zero_o, bnumz_o, bzero_o, e.n, e.z, f.n, f.z);
                end
                last32 = e;
                last8  = f;
            end else if (valid_o !== 1'b0 || numz_o !== last32.n[5:0] ||
                         zero_o !== last32.z || bvalid_o !== 1'b0 ||
                         bnumz_o !== last8.n[3:0] || bzero_o !== last8.z) begin
                failures++;
                $display("FAIL random_hold got v=%b n=%0d z=%b n8=%0d want 0 n=%0d z=%b n8=%0d",
                         valid_o, numz_o, zero_o, bnumz_o, last32.n, last32.z, last8.n);
            end
        end
    endtask

    task automatic test_mid_reset;
        apply(1'b1, 32'h10, 8'h10);
        void'(q32.pop_front());
        void'(q8.pop_front());
        valid_i = 1'b1;
        a_i     = 32'h4;
        b_i     = 8'h4;
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || numz_o !== 6'd0 || zero_o !== 1'b0 ||
            bvalid_o !== 1'b0 || bnumz_o !== 4'd0) begin
            failures++;
            $display("FAIL midreset_async got v=%b n=%0d z=%b v8=%b n8=%0d want 0",
                     valid_o, numz_o, zero_o, bvalid_o, bnumz_o);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        #2;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (valid_o !== 1'b0 || bvalid_o !== 1'b0 || numz_o !== 6'd0) begin
                failures++;
                $display("FAIL midreset_stale cyc=%0d got v=%b v8=%b n=%0d want 0 0 0",
                         i, valid_o, bvalid_o, numz_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_walk();
        test_boundary();
        test_hold();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
